ahb_lite_master_bridge: RTL and testbench

Single-outstanding-pipeline AHB-Lite master that converts a valid/ready command stream into AHB-Lite NONSEQ single transfers and returns per-transfer responses through a buffered valid/ready response stream. It sits directly upstream of the AHB-Lite memory slave (`ahb_lite_slave`) and is the bus-driving stage that test sequencers and internal requesters use. Address and data phases overlap, so one transfer per cycle is sustained with zero wait states.

---
 rtl/ahb_lite_master_bridge.sv | 183 ++++++++++++++++++
 tb/tb_ahb_lite_master_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master_bridge.sv
// AHB-Lite master: valid/ready commands become NONSEQ single transfers with overlapped
// address/data phases; responses return in order through a credit-protected FIFO.
// Optional build macro AHB_MST_ALIGN_CHECK_EN rejects oversize/misaligned commands locally.
module ahb_lite_master_bridge #(
  parameter int RSP_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic              a_valid_q, a_valid_d;
  logic [31:0]       haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [31:0]       a_wdata_q, a_wdata_d;
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              ill_valid_q, ill_valid_d;
  logic              ill_write_q, ill_write_d;
  logic              fifo_write_q [RSP_DEPTH];
  logic              fifo_write_d [RSP_DEPTH];
  logic [31:0]       fifo_rdata_q [RSP_DEPTH];
  logic [31:0]       fifo_rdata_d [RSP_DEPTH];
  logic              fifo_err_q   [RSP_DEPTH];
  logic              fifo_err_d   [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic             illegal, credit_ok, accept, issue, a_adv, d_done, push, pop;
  logic [CNT_W-1:0] credit_sum;

`ifdef AHB_MST_ALIGN_CHECK_EN
  always_comb begin
    illegal = 1'b0;
    if (cmd_size > 3'b010)                             illegal = 1'b1;
    else if (cmd_size == 3'b001 && cmd_addr[0])        illegal = 1'b1;
    else if (cmd_size == 3'b010 && cmd_addr[1:0] != 2'b00) illegal = 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Every accepted command owns a FIFO slot until popped, so the FIFO can never overflow.
  assign credit_sum = count_q + CNT_W'(a_valid_q) + CNT_W'(d_valid_q) + CNT_W'(ill_valid_q);
  assign credit_ok  = credit_sum < CNT_W'(RSP_DEPTH);
  assign cmd_ready  = !HRESET && credit_ok &&
                      (illegal ? (!a_valid_q && !d_valid_q) : (!a_valid_q || HREADY));
  assign accept     = cmd_valid && cmd_ready;
  assign issue      = accept && !illegal;
  assign a_adv      = a_valid_q && HREADY;
  assign d_done     = d_valid_q && HREADY;
  assign push       = d_done || ill_valid_q;
  assign pop        = (count_q != '0) && rsp_ready;

  // Address phase
  always_comb begin
    a_valid_d = a_valid_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    a_wdata_d = a_wdata_q;
    if (issue) begin
      a_valid_d = 1'b1;
      haddr_d   = cmd_addr;
      hwrite_d  = cmd_write;
      hsize_d   = cmd_size;
      a_wdata_d = cmd_wdata;
    end else if (HREADY) begin
      a_valid_d = 1'b0;
    end
    ill_valid_d = accept && illegal;
    ill_write_d = cmd_write;
  end

  // Data phase
  always_comb begin
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    hwdata_d  = hwdata_q;
    if (a_adv) begin
      d_valid_d = 1'b1;
      d_write_d = hwrite_q;
      hwdata_d  = a_wdata_q;
    end else if (d_done) begin
      d_valid_d = 1'b0;
    end
  end

  // Response FIFO
  always_comb begin
    fifo_write_d = fifo_write_q;
    fifo_rdata_d = fifo_rdata_q;
    fifo_err_d   = fifo_err_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      if (ill_valid_q) begin
        fifo_write_d[wr_ptr_q] = ill_write_q;
        fifo_rdata_d[wr_ptr_q] = 32'h0;
        fifo_err_d[wr_ptr_q]   = 1'b1;
      end else begin
        fifo_write_d[wr_ptr_q] = d_write_q;
        fifo_rdata_d[wr_ptr_q] = d_write_q ? 32'h0 : HRDATA;
        fifo_err_d[wr_ptr_q]   = HRESP;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      haddr_q     <= 32'h0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      d_valid_q   <= 1'b0;
      hwdata_q    <= 32'h0;
      ill_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      d_valid_q   <= d_valid_d;
      hwdata_q    <= hwdata_d;
      ill_valid_q <= ill_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge HCLK) begin
    a_wdata_q    <= a_wdata_d;
    d_write_q    <= d_write_d;
    ill_write_q  <= ill_write_d;
    fifo_write_q <= fifo_write_d;
    fifo_rdata_q <= fifo_rdata_d;
    fifo_err_q   <= fifo_err_d;
  end

  assign HTRANS    = a_valid_q ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  // Head fields are masked while empty so stale FIFO contents never leak out.
  assign rsp_valid = count_q != '0;
  assign rsp_write = rsp_valid && fifo_write_q[rd_ptr_q];
  assign rsp_rdata = rsp_valid ? fifo_rdata_q[rd_ptr_q] : 32'h0;
  assign rsp_err   = rsp_valid && fifo_err_q[rd_ptr_q];

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Scoreboard bench for ahb_lite_master_bridge with a small zero/variable-wait AHB slave model.
module tb_ahb_lite_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;

  ahb_lite_master_bridge #(.RSP_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic w; logic [31:0] rdata; logic err; int acc; int lat; } exp_t;
  typedef struct { int cyc; logic [31:0] addr; logic w; } bus_t;
  exp_t sb[$];
  bus_t blog[$];

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Slave model: word memory with preloaded words at 0x20/0x24; 0x400 returns an error.
  logic [31:0] mem [0:255];
  logic        dph_v, dph_w;
  logic [31:0] dph_addr;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dph_v <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8] <= 32'h1111_2222;
      mem[9] <= 32'h3333_4444;
    end else if (HREADY) begin
      if (dph_v && dph_w) mem[dph_addr[9:2]] <= HWDATA;
      dph_v    <= (HTRANS == 2'b10);
      dph_addr <= HADDR;
      dph_w    <= HWRITE;
    end
  end

  assign HRDATA = (dph_v && !dph_w) ?
                  ((dph_addr == 32'h400) ? 32'hDEAD_BEEF : mem[dph_addr[9:2]]) : 32'h0;
  assign HRESP  = dph_v && (dph_addr == 32'h400);

  always @(negedge HCLK) begin
    if (!HRESET && HTRANS == 2'b10 && HREADY)
      blog.push_back('{cyc: cyc, addr: HADDR, w: HWRITE});
  end

  // Monitor: every response handshake is compared against the scoreboard head.
  always @(negedge HCLK) begin
    if (!HRESET && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=%h required=none", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_write", 32'(rsp_write), 32'(e.w));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.lat != 0) chk("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee,
                      input int lat);
    bit done = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge HCLK);
      if (cmd_ready) begin
        sb.push_back('{w: w, rdata: er, err: ee, acc: cyc + 1, lat: lat});
        done = 1;
      end
      @(posedge HCLK); #1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout actual=not_accepted required=accepted addr=%h", a);
    end
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) begin
      @(posedge HCLK); #1;
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_size = 3'b010;
    cmd_wdata = 32'h1234_5678;

    // Reset with a command pending
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      chk("rst_htrans", 32'(HTRANS), 32'd0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'd0);
      chk("rst_hsize", 32'(HSIZE), 32'd0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_write", 32'(rsp_write), 32'd0);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0; cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("post_rst_idle", 32'(HTRANS), 32'd0);
    chk("post_rst_no_transfer", 32'(blog.size()), 32'd0);
    @(posedge HCLK); #1;

    // Write then read back-to-back
    blog.delete();
    send(1'b1, 32'h10, 3'b010, 32'hA5A5_1234, 32'h0, 1'b0, 2);
    send(1'b0, 32'h10, 3'b010, 32'h0, 32'hA5A5_1234, 1'b0, 2);
    drain(20);
    chk("wr_rd_nonseq_count", 32'(blog.size()), 32'd2);
    if (blog.size() == 2) begin
      chk("wr_rd_addr0", blog[0].addr, 32'h10);
      chk("wr_rd_write0", 32'(blog[0].w), 32'd1);
      chk("wr_rd_write1", 32'(blog[1].w), 32'd0);
      chk("wr_rd_consecutive", blog[1].cyc - blog[0].cyc, 32'd1);
    end

    // Wait states: 3 stalled cycles during the first read's data phase
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_size = 3'b010;
    @(negedge HCLK);
    chk("ws_accept0", 32'(cmd_ready), 32'd1);
    sb.push_back('{w: 1'b0, rdata: 32'h1111_2222, err: 1'b0, acc: cyc + 1, lat: 5});
    @(posedge HCLK); #1;
    cmd_addr = 32'h24;
    @(negedge HCLK);
    chk("ws_accept1", 32'(cmd_ready), 32'd1);
    sb.push_back('{w: 1'b0, rdata: 32'h3333_4444, err: 1'b0, acc: cyc + 1, lat: 5});
    @(posedge HCLK); #1;
    cmd_valid = 1'b0; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("ws_haddr_hold", HADDR, 32'h24);
      chk("ws_htrans_hold", 32'(HTRANS), 32'd2);
      @(posedge HCLK); #1;
    end
    HREADY = 1'b1;
    drain(20);

    // Slave error response
    send(1'b0, 32'h400, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b1, 2);
    drain(20);

    // Backpressure: only RSP_DEPTH commands fit while responses are held
    rsp_ready = 1'b0;
    send(1'b1, 32'h40, 3'b010, 32'h4040_4040, 32'h0, 1'b0, 0);
    send(1'b1, 32'h44, 3'b010, 32'h4444_4444, 32'h0, 1'b0, 0);
    send(1'b1, 32'h48, 3'b010, 32'h4848_4848, 32'h0, 1'b0, 0);
    send(1'b1, 32'h4C, 3'b010, 32'h4C4C_4C4C, 32'h0, 1'b0, 0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_size = 3'b010;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      @(posedge HCLK); #1;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    send(1'b0, 32'h40, 3'b010, 32'h0, 32'h4040_4040, 1'b0, 0);
    send(1'b0, 32'h4C, 3'b010, 32'h0, 32'h4C4C_4C4C, 1'b0, 0);
    drain(40);

    // Misaligned word write followed by a legal read
    blog.delete();
`ifdef AHB_MST_ALIGN_CHECK_EN
    send(1'b1, 32'h3, 3'b010, 32'h0BAD_F00D, 32'h0, 1'b1, 1);
    send(1'b0, 32'h20, 3'b010, 32'h0, 32'h1111_2222, 1'b0, 2);
    drain(20);
    chk("align_nonseq_count", 32'(blog.size()), 32'd1);
    if (blog.size() == 1) chk("align_legal_addr", blog[0].addr, 32'h20);
`else
    send(1'b1, 32'h3, 3'b010, 32'h0BAD_F00D, 32'h0, 1'b0, 2);
    send(1'b0, 32'h20, 3'b010, 32'h0, 32'h1111_2222, 1'b0, 2);
    drain(20);
    chk("noalign_nonseq_count", 32'(blog.size()), 32'd2);
    if (blog.size() == 2) chk("noalign_addr", blog[0].addr, 32'h3);
`endif

    repeat (3) @(posedge HCLK);
    #1;
    chk("final_rsp_valid", 32'(rsp_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
